// File: rtl/mips_mem_pkg.sv
// Shared types for the MEM-stage data-memory access sequencer:
// FSM states, access kinds decoded from the load/store controls, and width constants.
package mips_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        LW,
        LH,
        LHU,
        SW
    } kind_e;

    // LoadHalf/LoadHalfUnsigned only qualify loads, so a store is always a full word.
    function automatic kind_e decode_kind(input logic mem_write, input logic load_half,
                                          input logic load_half_u);
        if (mem_write)        return SW;
        else if (load_half)   return LH;
        else if (load_half_u) return LHU;
        else                  return LW;
    endfunction

    function automatic logic is_misaligned(input kind_e kind, input logic [1:0] lsb);
        if (kind == LH || kind == LHU) return lsb[0];
        else                           return |lsb;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Big-endian halfword select and sign/zero extension of a loaded word.
// Stores produce zero so the result can be registered unconditionally on ack.
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic              addr1_i,
    input  kind_e             kind_i,
    output logic [WORD_W-1:0] result_o
);

    logic [HALF_W-1:0] half;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        result_o = '0;
        half     = addr1_i ? word_i[HALF_W-1:0] : word_i[WORD_W-1:HALF_W];
        case (kind_i)
            LW:      result_o = word_i;
            LH:      result_o = {{(WORD_W-HALF_W){half[HALF_W-1]}}, half};
            LHU:     result_o = {{(WORD_W-HALF_W){1'b0}}, half};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: captures a decoded load/store, runs one req/ack transaction
// against the data memory with a timeout, and returns formatted load data with fault status.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              LoadHalf,
    input  logic              LoadHalfUnsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] rdata,
    output logic              done,
    output logic              fault,
    output logic              stall
);

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    kind_e               kind_q;
    logic                we_q;
    logic [ADDR_W-3:0]   addr_q;
    logic                addr1_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WORD_W-1:0]   rdata_q;
    logic                fault_q;

    kind_e               cap_kind;
    logic                accept;
    logic                cap_fault;
    logic                timed_out;
    logic [WORD_W-1:0]   load_word;

    assign cap_kind  = decode_kind(MemWrite, LoadHalf, LoadHalfUnsigned);
    assign accept    = start && (MemRead || MemWrite);
    assign cap_fault = (MemRead && MemWrite) || (LoadHalf && LoadHalfUnsigned) ||
                       is_misaligned(cap_kind, addr[1:0]);
    assign timed_out = (cnt_q == CNT_LAST);

    load_extend u_load_extend (
        .word_i   (mem_rdata),
        .addr1_i  (addr1_q),
        .kind_i   (kind_q),
        .result_o (load_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = cap_fault ? DONE : REQ;
            REQ:  if (mem_ack || timed_out) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state_q == REQ);
        done    = (state_q == DONE);
        fault   = (state_q == DONE) && fault_q;
        stall   = ((state_q == IDLE) && accept) || (state_q == REQ);
    end

    // Capture registers, timeout counter and result; ack wins over a same-cycle timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q  <= LW;
            we_q    <= 1'b0;
            addr_q  <= '0;
            addr1_q <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        kind_q  <= cap_kind;
                        we_q    <= MemWrite;
                        addr_q  <= addr[ADDR_W-1:2];
                        addr1_q <= addr[1];
                        wdata_q <= wdata;
                        cnt_q   <= '0;
                        rdata_q <= '0;
                        fault_q <= cap_fault;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        rdata_q <= load_word;
                        fault_q <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access sequencer for the MIPS datapath, sitting in the MEM stage downstream of the instruction decoder. It consumes the decoded memory controls (MemRead, MemWrite, LoadHalf, LoadHalfUnsigned) with the effective address and store data. It runs a req/ack transaction against a word-wide, variable-latency data memory and returns load data with halfword select and sign or zero extension. It stalls the pipeline until the access completes, and flags misaligned, conflicting or timed-out accesses.

## Interface
- ADDR_W, 32, byte address width
- TIMEOUT, 255, max REQ cycles without mem_ack before fault (≥1)
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- start  in  1  MEM stage presents an access this cycle
- MemRead, MemWrite  in  1  decoded load / store controls
- LoadHalf, LoadHalfUnsigned  in  1  decoded lh / lhu controls (qualify MemRead)
- addr  in  ADDR_W  byte effective address
- wdata  in  32  store data (sw only, full word)
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W-2  word address (addr[ADDR_W-1:2])
- mem_wdata  out  32  write data
- mem_ack  in  1  memory completes request this cycle
- mem_rdata  in  32  read word, valid with mem_ack
- rdata  out  32  load result, valid while done=1
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; access aborted
- stall  out  1  hold upstream pipeline

## Operation
- States: IDLE, REQ, DONE. Encoded in the shared package.
- IDLE: start=1 with MemRead|MemWrite=1 is captured (controls, addr, wdata registered). start with both controls 0 is ignored: no stall, stay IDLE.
- Capture-time checks, any failing → DONE with fault=1, no mem_req:
  - MemRead&MemWrite both 1
  - LoadHalf&LoadHalfUnsigned both 1
  - lw/sw with addr[1:0]≠0
  - lh/lhu with addr[0]≠0
- Otherwise → REQ.
- REQ: mem_req=1. mem_we, mem_addr and mem_wdata stay stable from captured values. The timeout counter increments each REQ cycle with mem_ack=0.
  - mem_ack=1 → DONE. Load data is registered.
  - Counter reaches TIMEOUT → DONE with fault=1. mem_req drops.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start is not sampled in DONE.
- Load formatting is big-endian:
  - lw: rdata = mem_rdata
  - lh/lhu with addr[1]=0: halfword [31:16]
  - lh/lhu with addr[1]=1: halfword [15:0]
  - lh sign-extends; lhu zero-extends
- Stores and faults: rdata=0.
- start is ignored while in REQ or DONE. A mem_ack arriving in IDLE or DONE is ignored.

## Timing
- Reset values (first edge with reset=1): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, done=0, fault=0, counter=0.
- stall = (IDLE & start & (MemRead|MemWrite)) | REQ. stall is combinational on start and low in DONE, so the pipeline advances on the DONE cycle.
- Minimum latency (ack on first REQ cycle): start at cycle 0, mem_req at cycle 1, done at cycle 2.
- Fault on a capture-time check: start at cycle 0, done+fault at cycle 1.
- Timeout: mem_req is high for TIMEOUT cycles, then done+fault on the following cycle.
- Reset mid-operation: IDLE after the edge and mem_req=0. The memory must tolerate a dropped request.
- Back-to-back accesses: the next start is accepted in the cycle after DONE. Minimum spacing is 3 cycles.

## Structure
- Package mips_mem_pkg:
  - state enum {IDLE, REQ, DONE}
  - access-kind encoding {LW, LH, LHU, SW} derived from the controls
  - width constants
- Sub-module load_extend: combinational, inputs (word, addr[1], kind), output 32-bit result. Shared with any future lb/lbu support.
- Top level holds the FSM, capture registers, timeout counter and fault logic.

## Test plan
- lw at addr=0x0000_0010, mem_ack on first REQ cycle, mem_rdata=0xDEAD_BEEF → mem_addr=0x4, done at cycle 2, rdata=0xDEAD_BEEF, fault=0, stall high at cycles 0–1 only.
- lh at addr=0x12 with mem_rdata=0x1234_8001 → rdata=0xFFFF_8001. lhu at the same address → rdata=0x0000_8001. lh at addr=0x10 → rdata=0x0000_1234.
- sw at addr=0x20 with wdata=0xCAFE_F00D, ack after 5 REQ cycles → mem_we=1 and mem_wdata stable for 5 cycles, done one cycle after ack, rdata=0.
- Misaligned lw at addr=0x2, then MemRead=MemWrite=1 → each gives done+fault at cycle 1, mem_req never asserted.
- TIMEOUT=4, mem_ack held 0 → mem_req high for 4 cycles, then done+fault. A late mem_ack in IDLE is ignored.
- reset asserted in the 2nd REQ cycle → next cycle mem_req=0, stall=0, done=0. A subsequent lw completes normally.
